// File: rtl/sram_read_arbiter.sv
// rtl/sram_read_arbiter.sv - round-robin sharing of a 1R1W SRAM read port among NUM_REQ requesters
// Define SRAM_ARB_BYPASS_EN to forward colliding write data instead of stalling the grant.
module sram_1r1w #(
    parameter int DATA_WIDTH        = 32,
    parameter int SIZE              = 64,
    parameter int ADDR_WIDTH        = $clog2(SIZE),
    parameter     READ_DURING_WRITE = "DONT_CARE"
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);
    localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

    logic [DATA_WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        if (read_en) begin
            read_data <= (NEW_DATA && write_en && (write_addr == read_addr)) ? write_data
                                                                               : mem[read_addr];
        end
    end
endmodule

module sram_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 64,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [PTR_W-1:0]      win_idx;
    logic                  any_req;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  collision;
    logic                  grant_ok;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // Rotating priority search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && rd_req[idx]) begin
                any_req = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    assign win_addr  = rd_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign collision = any_req && wr_en && (wr_addr == win_addr);

`ifdef SRAM_ARB_BYPASS_EN
    assign grant_ok = any_req && !reset;
`else
    // The SRAM read-during-write result is undefined, so a colliding read waits one cycle.
    assign grant_ok = any_req && !reset && !collision;
`endif

    always_comb begin
        rd_grant = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_ok) begin
            rd_grant = NUM_REQ'(1) << win_idx;
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rd_grant;
        end
    end

    sram_1r1w #(
        .DATA_WIDTH       (DATA_WIDTH),
        .SIZE             (SIZE),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .READ_DURING_WRITE("DONT_CARE")
    ) u_sram (
        .clk       (clk),
        .read_en   (grant_ok),
        .read_addr (win_addr),
        .read_data (sram_rdata),
        .write_en  (wr_en),
        .write_addr(wr_addr),
        .write_data(wr_data)
    );

`ifdef SRAM_ARB_BYPASS_EN
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] fwd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_q <= 1'b0;
            fwd_q <= '0;
        end else begin
            byp_q <= grant_ok && collision;
            if (grant_ok && collision) begin
                fwd_q <= wr_data;
            end
        end
    end

    assign rsp_data = byp_q ? fwd_q : sram_rdata;
`else
    assign rsp_data = sram_rdata;
`endif

    assign rsp_valid = rsp_valid_q;
endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb/tb_sram_read_arbiter.sv - directed vector bench for sram_read_arbiter
module tb_sram_read_arbiter;
    localparam int DW = 32;
    localparam int SZ = 64;
    localparam int AW = 6;
    localparam int NR = 4;
`ifdef SRAM_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic [NR*AW-1:0] addrs;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [NR-1:0] eg;
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        logic          cd;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    rd_grant;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;

    int errors = 0;
    int checks = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    sram_read_arbiter #(
        .DATA_WIDTH(DW),
        .SIZE      (SZ),
        .ADDR_WIDTH(AW),
        .NUM_REQ   (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_grant (rd_grant),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    function automatic logic [NR*AW-1:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [NR*AW-1:0] addrs,
                                input logic we, input int wa, input logic [31:0] wd,
                                input logic [3:0] eg, input logic [3:0] ev,
                                input logic [31:0] ed, input logic cd);
        vec_t v;
        v.rst = rst; v.req = req; v.addrs = addrs; v.we = we; v.wa = AW'(wa); v.wd = wd;
        v.eg = eg; v.ev = ev; v.ed = ed; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [NR-1:0] req, input logic [NR*AW-1:0] addrs,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        reset   = rst;
        rd_req  = req;
        rd_addr = addrs;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
    endtask

    initial begin
        logic [NR*AW-1:0] a12;
        logic [NR*AW-1:0] z;
        a12 = pk(12, 12, 12, 12);
        z   = '0;

        drive(1'b1, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state and basic read-back
        tv.push_back(mk(1, 4'b1111, a12, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 1, 12, 32'h245fa7d4, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 1, 17, 32'h07b8261b, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0001, pk(0, 0, 0, 12), 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0001, 32'h245fa7d4, 1));
        // Round robin from a fresh pointer
        tv.push_back(mk(1, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0010, 4'b0001, 32'h245fa7d4, 1));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0100, 4'b0010, 32'h245fa7d4, 1));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b1000, 4'b0100, 32'h245fa7d4, 1));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0001, 4'b1000, 32'h245fa7d4, 1));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0010, 4'b0001, 0, 0));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0100, 4'b0010, 0, 0));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b1000, 4'b0100, 0, 0));
        // Requester 1 drops out
        tv.push_back(mk(0, 4'b1101, a12, 0, 0, 0, 4'b0001, 4'b1000, 0, 0));
        tv.push_back(mk(0, 4'b1101, a12, 0, 0, 0, 4'b0100, 4'b0001, 0, 0));
        tv.push_back(mk(0, 4'b1101, a12, 0, 0, 0, 4'b1000, 4'b0100, 0, 0));
        tv.push_back(mk(0, 4'b1101, a12, 0, 0, 0, 4'b0001, 4'b1000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0001, 32'h245fa7d4, 1));
        // Read and write to different addresses
        tv.push_back(mk(0, 4'b0010, pk(0, 0, 17, 0), 1, 19, 32'h47b06ea2, 4'b0010, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0010, pk(0, 0, 19, 0), 0, 0, 0, 4'b0010, 4'b0010, 32'h07b8261b, 1));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0010, 32'h47b06ea2, 1));
        // Same-address collision
        tv.push_back(mk(0, 4'b0100, pk(0, 19, 0, 0), 1, 19, 32'hdff64bb1,
                        BYP ? 4'b0100 : 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, BYP ? 4'b0000 : 4'b0100, pk(0, 19, 0, 0), 0, 0, 0,
                        BYP ? 4'b0000 : 4'b0100, BYP ? 4'b0100 : 4'b0000, 32'hdff64bb1, BYP));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000,
                        BYP ? 4'b0000 : 4'b0100, 32'hdff64bb1, !BYP));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        // Reset asserted while a grant would occur
        tv.push_back(mk(1, 4'b1000, a12, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b1111, a12, 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
        tv.push_back(mk(1, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0001, 32'h245fa7d4, 1));
        tv.push_back(mk(0, 4'b1100, a12, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
        tv.push_back(mk(0, 4'b0000, z, 0, 0, 0, 4'b0000, 4'b0100, 32'h245fa7d4, 1));

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].req, tv[i].addrs, tv[i].we, tv[i].wa, tv[i].wd);
            #1;
            chk($sformatf("v%0d grant", i), 32'(rd_grant), 32'(tv[i].eg));
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].ev));
            if (tv[i].cd) begin
                chk($sformatf("v%0d rsp_data", i), rsp_data, tv[i].ed);
            end
            @(negedge clk);
        end

        // Back-to-back reads by requester 2 with a new address each grant
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(40 + j), 32'hc3a50000 + 32'(j) * 32'h00011111);
            @(negedge clk);
        end
        for (int j = 0; j < 6; j++) begin
            if (j < 5) begin
                drive(1'b0, 4'b0100, pk(0, 40 + j, 0, 0), 1'b0, '0, '0);
            end else begin
                drive(1'b0, '0, '0, 1'b0, '0, '0);
            end
            #1;
            chk($sformatf("b2b%0d grant", j), 32'(rd_grant), (j < 5) ? 32'h4 : 32'h0);
            chk($sformatf("b2b%0d rsp_valid", j), 32'(rsp_valid), (j > 0) ? 32'h4 : 32'h0);
            if (j > 0) begin
                chk($sformatf("b2b%0d rsp_data", j), rsp_data,
                    32'hc3a50000 + 32'(j - 1) * 32'h00011111);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
